fibo_arbiter: RTL and testbench

- Round-robin scheduler that shares one fibo computation unit among NREQ requesters.
- Latches the winning requester's n and launches the unit with a one-cycle start.
- Waits for finished, with a timeout guard, then returns the result with a one-cycle done pulse to the owner.
- Sits between the client blocks and the single fibo datapath instance.

---
 rtl/fibo_arbiter.sv | 140 ++++++++++++++
 tb/tb_fibo_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fibo_arbiter.sv
// fibo_arbiter: round-robin scheduler sharing one fibo unit among NREQ clients.
// Latches the winner's operand, pulses fibo_start, waits for fibo_finished
// (bounded by TIMEOUT), then returns result/err with a done pulse to the owner.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no job; arbitrate from ptr each cycle
// ST_LAUNCH | fibo_start high for this single cycle
// ST_GUARD  | finished ignored (masks a stale level); timeout counter cleared
// ST_WAIT   | wait for finished or TIMEOUT-th wait cycle
// ST_REPLY  | done pulse to owner; result/err valid
module fibo_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int CW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_n,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   done,
  output logic [7:0]        result,
  output logic              err,
  output logic              busy,
  output logic [7:0]        fibo_n,
  output logic              fibo_start,
  input  logic [7:0]        fibo_result,
  input  logic              fibo_finished
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_GUARD,
    ST_WAIT,
    ST_REPLY
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [CW-1:0] cnt;

  logic [IW-1:0] cand;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic [7:0]    win_n;

  // Round-robin search starting at ptr; first active request wins.
  always_comb begin
    cand      = '0;
    win_idx   = '0;
    win_found = 1'b0;
    win_n     = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IW'(k)) begin
        win_n = req_n[8*k +: 8];
      end
    end
  end

  // Job sequencing FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      owner      <= '0;
      cnt        <= '0;
      grant      <= '0;
      done       <= '0;
      result     <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      fibo_n     <= '0;
      fibo_start <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= '0;
          if (win_found) begin
            owner      <= win_idx;
            grant      <= NREQ'(1) << win_idx;
            fibo_n     <= win_n;
            busy       <= 1'b1;
            fibo_start <= 1'b1;
            state      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          fibo_start <= 1'b0;
          state      <= ST_GUARD;
        end
        ST_GUARD: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fibo_finished) begin
            result <= fibo_result;
            err    <= 1'b0;
            done   <= grant;
            state  <= ST_REPLY;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            result <= '0;
            err    <= 1'b1;
            done   <= grant;
            state  <= ST_REPLY;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_REPLY: begin
          done  <= '0;
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state      <= ST_IDLE;
          grant      <= '0;
          done       <= '0;
          busy       <= 1'b0;
          fibo_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_arbiter.sv
// Directed bench for fibo_arbiter with a behavioural fibo unit model.
module tb_fibo_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_n;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [7:0]  result;
  logic        err;
  logic        busy;
  logic [7:0]  fibo_n;
  logic        fibo_start;
  logic [7:0]  fibo_result = 8'd0;
  logic        fibo_finished = 1'b0;

  int checks   = 0;
  int failures = 0;

  int model_delay  = 10;
  bit never_finish = 1'b0;
  bit level_mode   = 1'b0;

  fibo_arbiter #(.NREQ(4), .TIMEOUT(16), .CW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .req_n(req_n),
    .grant(grant), .done(done), .result(result), .err(err), .busy(busy),
    .fibo_n(fibo_n), .fibo_start(fibo_start),
    .fibo_result(fibo_result), .fibo_finished(fibo_finished)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fib(input logic [7:0] n);
    logic [7:0] a, b, t;
    a = 8'd0;
    b = 8'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Fibo unit model: finishes model_delay cycles after the start pulse; a
  // level-mode finish stays high until two cycles after the next start.
  logic [7:0] job_n = 8'd0;
  int  left = 0;
  bit  run  = 1'b0;
  int  drop = 0;
  bit  clr  = 1'b0;
  always @(negedge clk) begin
    if (fibo_start) begin
      job_n = fibo_n;
      left  = model_delay;
      run   = !never_finish;
      drop  = 2;
    end else begin
      if (clr) begin
        fibo_finished = 1'b0;
        clr = 1'b0;
      end
      if (drop > 0) begin
        drop--;
        if (drop == 0) fibo_finished = 1'b0;
      end
      if (run) begin
        left--;
        if (left == 0) begin
          fibo_finished = 1'b1;
          fibo_result   = fib(job_n);
          run = 1'b0;
          clr = !level_mode;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ticks until done rises (bounded), checking latency and that grant holds.
  task automatic await_done(input string tag, input int exp_cyc, input logic [3:0] exp_grant);
    int n;
    bit gok;
    n = 0;
    gok = 1'b1;
    while (done == 4'd0 && n < 60) begin
      tick();
      n++;
      if (grant !== exp_grant) gok = 1'b0;
    end
    chk({tag, "_latency"}, n, exp_cyc);
    chk({tag, "_grant_held"}, 32'(gok), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'(exp_grant));
  endtask

  logic [7:0] fair_res [4];

  initial begin
    fair_res[0] = 8'd1; fair_res[1] = 8'd1; fair_res[2] = 8'd2; fair_res[3] = 8'd3;
    reset = 1'b1;
    req   = 4'b0000;
    req_n = 32'd0;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_fibo_n", 32'(fibo_n), 0);
    chk("rst_start", 32'(fibo_start), 0);
    reset = 1'b0;

    // Single job, n=6, finish 10 cycles after start; req_n changes after E0.
    model_delay = 10;
    req = 4'b0001;
    req_n[7:0] = 8'd6;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_busy", 32'(busy), 1);
    chk("t1_fibo_n", 32'(fibo_n), 6);
    chk("t1_start", 32'(fibo_start), 1);
    req_n[7:0] = 8'd99;
    tick();
    chk("t1_start_one_cycle", 32'(fibo_start), 0);
    await_done("t1", 10, 4'b0001);
    chk("t1_result", 32'(result), 8);
    chk("t1_err", 32'(err), 0);
    req = 4'b0000;
    tick();
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_idle_grant", 32'(grant), 0);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_result_held", 32'(result), 8);

    // Simultaneous req[0] n=5 and req[2] n=7 from ptr=0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_delay = 3;
    req = 4'b0101;
    req_n = {8'd0, 8'd7, 8'd0, 8'd5};
    tick();
    chk("t2_first_grant", 32'(grant), 32'h1);
    chk("t2_first_n", 32'(fibo_n), 5);
    await_done("t2a", 4, 4'b0001);
    chk("t2a_result", 32'(result), 5);
    req = 4'b0100;
    tick();
    tick();
    chk("t2_second_grant", 32'(grant), 32'h4);
    chk("t2_second_n", 32'(fibo_n), 7);
    await_done("t2b", 4, 4'b0100);
    chk("t2b_result", 32'(result), 13);
    // ptr should now be 3: req[3] beats req[0].
    req = 4'b1001;
    req_n = {8'd2, 8'd0, 8'd0, 8'd1};
    tick();
    tick();
    chk("t2_ptr3_grant", 32'(grant), 32'h8);
    await_done("t2c", 4, 4'b1000);
    chk("t2c_result", 32'(result), 1);

    // Fairness: all requests held, n=1..4, minimum-latency jobs.
    model_delay = 2;
    req = 4'b1111;
    req_n = {8'd4, 8'd3, 8'd2, 8'd1};
    tick();
    chk("t3_idle_gap_busy", 32'(busy), 0);
    tick();
    for (int j = 0; j < 6; j++) begin
      chk("t3_grant", 32'(grant), 32'(4'b0001 << (j % 4)));
      chk("t3_start", 32'(fibo_start), 1);
      await_done("t3", 3, 4'(4'b0001 << (j % 4)));
      chk("t3_result", 32'(result), 32'(fair_res[j % 4]));
      if (j == 5) req = 4'b0000;
      tick();
      chk("t3_gap_busy", 32'(busy), 0);
      chk("t3_gap_grant", 32'(grant), 0);
      if (j < 5) tick();
    end

    // Stale finished: job A leaves finished high; job B must not capture it.
    level_mode  = 1'b1;
    model_delay = 2;
    req = 4'b0010;
    req_n = {8'd0, 8'd0, 8'd5, 8'd0};
    tick();
    chk("t4a_grant", 32'(grant), 32'h2);
    await_done("t4a", 3, 4'b0010);
    chk("t4a_result", 32'(result), 5);
    model_delay = 4;
    req = 4'b0100;
    req_n = {8'd0, 8'd6, 8'd0, 8'd0};
    tick();
    tick();
    chk("t4b_grant", 32'(grant), 32'h4);
    await_done("t4b", 5, 4'b0100);
    chk("t4b_result", 32'(result), 8);
    chk("t4b_err", 32'(err), 0);

    // Timeout with TIMEOUT=16, then a normal job.
    level_mode   = 1'b0;
    never_finish = 1'b1;
    req = 4'b1001;
    req_n = {8'd4, 8'd0, 8'd0, 8'd7};
    tick();
    tick();
    chk("t5_grant", 32'(grant), 32'h8);
    await_done("t5", 18, 4'b1000);
    chk("t5_err", 32'(err), 1);
    chk("t5_result", 32'(result), 0);
    never_finish = 1'b0;
    model_delay  = 3;
    req = 4'b0001;
    tick();
    tick();
    chk("t5n_grant", 32'(grant), 32'h1);
    await_done("t5n", 4, 4'b0001);
    chk("t5n_result", 32'(result), 13);
    chk("t5n_err", 32'(err), 0);

    // Reset during WAIT aborts the job; ptr returns to 0.
    model_delay = 10;
    req = 4'b0010;
    req_n = {8'd0, 8'd0, 8'd6, 8'd0};
    tick();
    tick();
    chk("t6_grant", 32'(grant), 32'h2);
    repeat (3) tick();
    chk("t6_busy_wait", 32'(busy), 1);
    reset = 1'b1;
    req = 4'b0000;
    tick();
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(done), 0);
    reset = 1'b0;
    model_delay = 3;
    req = 4'b0011;
    req_n = {8'd0, 8'd0, 8'd6, 8'd3};
    tick();
    chk("t6_no_done", 32'(done), 0);
    chk("t6_ptr0_grant", 32'(grant), 32'h1);
    await_done("t6a", 4, 4'b0001);
    chk("t6a_result", 32'(result), 2);
    req = 4'b0010;
    tick();
    tick();
    chk("t6b_grant", 32'(grant), 32'h2);
    chk("t6b_fibo_n", 32'(fibo_n), 6);
    await_done("t6b", 4, 4'b0010);
    chk("t6b_result", 32'(result), 8);
    req = 4'b0000;
    tick();
    chk("t6_end_grant", 32'(grant), 0);
    chk("t6_end_done", 32'(done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
